// File: rtl/m90_palette.sv
// rtl/m90_palette.sv - GA25 colour index to RGB palette stage with CPU slot arbitration
// Optional feature macro: M90_PALETTE_CLEAR_EN (zero the palette RAM after reset).
module m90_palette #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic              pal_cs,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [11:0]       addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              busy,
    input  logic [ADDR_W-1:0] color_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hblank,
    output logic              vblank,
    output logic              hsync,
    output logic              vsync
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_CLEAR} state_t;

`ifdef M90_PALETTE_CLEAR_EN
    localparam state_t STATE_RST = S_CLEAR;
    localparam logic   BUSY_RST  = 1'b1;
`else
    localparam state_t STATE_RST = S_IDLE;
    localparam logic   BUSY_RST  = 1'b0;
`endif

    state_t            state, state_nx;
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    logic              req_now, req_prev, req_pend, req_wr, latch, go_access;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_data;

    logic              pix_pend;
    logic [14:0]       pix_word;
    logic              s1_hb, s1_vb, s1_hs, s1_vs;
    logic              unused_addr0;

    function automatic logic [7:0] expand(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign unused_addr0 = addr[0];
    assign ram_q        = mem[ram_addr];
    assign req_now      = pal_cs & (mem_rd | mem_wr);
    // CPU only gets a slot on a clock that is not a pixel slot
    assign go_access    = (state == S_IDLE) && req_pend && !ce_pix;

`ifdef M90_PALETTE_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_step, clr_last;
    assign clr_step = (state == S_CLEAR) && !ce_pix;
    assign clr_last = clr_step && (clr_cnt == '1);
    assign latch    = req_now && !req_prev && !req_pend && (!busy || state == S_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            clr_cnt <= '0;
        else if (clr_step)
            clr_cnt <= clr_cnt + 1'b1;
    end
`else
    assign latch = req_now && !req_prev && !busy;
`endif

    always_comb begin
        wr_en   = go_access && req_wr;
        wr_addr = req_addr;
        wr_data = req_data;
`ifdef M90_PALETTE_CLEAR_EN
        if (clr_step) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end
`endif
    end

    // RAM contents survive reset; writes are simply blocked while it is held
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= STATE_RST;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (go_access) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
`ifdef M90_PALETTE_CLEAR_EN
            S_CLEAR:  if (clr_last) state_nx = S_IDLE;
`endif
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_prev <= 1'b0;
            req_pend <= 1'b0;
            req_wr   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            cpu_dout <= '0;
            busy     <= BUSY_RST;
        end else begin
            req_prev <= req_now;
            if (latch) begin
                req_pend <= 1'b1;
                req_wr   <= mem_wr;
                req_addr <= ADDR_W'(addr[11:1]);
                req_data <= cpu_din;
                busy     <= 1'b1;
            end
            if (go_access)
                req_pend <= 1'b0;
            if (state == S_ACCESS) begin
                if (!req_wr)
                    cpu_dout <= ram_q;
                busy <= 1'b0;
            end
`ifdef M90_PALETTE_CLEAR_EN
            if (clr_last)
                busy <= req_pend | latch;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            pix_pend <= 1'b0;
            pix_word <= '0;
            s1_hb    <= 1'b1;
            s1_vb    <= 1'b1;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            hblank   <= 1'b1;
            vblank   <= 1'b1;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
        end else if (ce_pix) begin
            ram_addr <= color_in;
            pix_pend <= 1'b1;
            s1_hb    <= hblank_in;
            s1_vb    <= vblank_in;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            red      <= (s1_hb | s1_vb) ? 8'd0 : expand(pix_word[4:0]);
            green    <= (s1_hb | s1_vb) ? 8'd0 : expand(pix_word[9:5]);
            blue     <= (s1_hb | s1_vb) ? 8'd0 : expand(pix_word[14:10]);
            hblank   <= s1_hb;
            vblank   <= s1_vb;
            hsync    <= s1_hs;
            vsync    <= s1_vs;
        end else begin
            if (pix_pend) begin
                pix_word <= ram_q[14:0];
                pix_pend <= 1'b0;
            end
            if (go_access)
                ram_addr <= req_addr;
        end
    end
endmodule
